// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over an 8-bit memory port; non-memory ops pass straight through.
// Optional: define MISALIGN_CHECK_EN to reject misaligned halfword/word accesses with a misalign_err pulse.
`ifndef RegAddressBus
`define RegAddressBus 4:0
`endif
`ifndef InstShort
`define InstShort 5:0
`endif
`ifndef MEM_STAGE_INST_CODES
`define MEM_STAGE_INST_CODES
`define INST_NOP  6'd0
`define INST_ADDI 6'd1
`define INST_LB   6'd10
`define INST_LH   6'd11
`define INST_LW   6'd12
`define INST_LBU  6'd13
`define INST_LHU  6'd14
`define INST_SB   6'd15
`define INST_SH   6'd16
`define INST_SW   6'd17
`endif

module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [`RegAddressBus] rd_address_in,
  input  logic [XLEN-1:0]       rd_data_in,
  input  logic [`InstShort]     inst_in,
  input  logic [ADDR_W-1:0]     mem_address_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_grant,
  input  logic                  mem_rvalid,
  input  logic [7:0]            mem_rdata,
  output logic                  stall_req,
  output logic [`RegAddressBus] rd_address_out,
  output logic [XLEN-1:0]       rd_data_out,
  output logic                  mem_rd_done,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [`InstShort]     r_inst;
  logic [ADDR_W-1:0]     r_addr;
  logic [`RegAddressBus] r_rd;
  logic [XLEN-1:0]       r_data;
  logic [2:0]            r_idx;
  logic [31:0]           r_acc;

  logic [2:0]            w_inCount;
  logic                  w_inMem;
  logic [2:0]            w_curCount;
  logic                  w_curStore;
  logic                  w_lastByte;
  logic [4:0]            w_byteSel;
  logic                  w_misaligned;
  logic [XLEN-1:0]       w_loadData;

  function automatic logic [2:0] byteCount(input logic [`InstShort] inst);
    case (inst)
      `INST_LB, `INST_LBU, `INST_SB: byteCount = 3'd1;
      `INST_LH, `INST_LHU, `INST_SH: byteCount = 3'd2;
      `INST_LW, `INST_SW:            byteCount = 3'd4;
      default:                       byteCount = 3'd0;
    endcase
  endfunction

  function automatic logic isStore(input logic [`InstShort] inst);
    isStore = (inst == `INST_SB) || (inst == `INST_SH) || (inst == `INST_SW);
  endfunction

  assign w_inCount  = byteCount(inst_in);
  assign w_inMem    = (w_inCount != 3'd0);
  assign w_curCount = byteCount(r_inst);
  assign w_curStore = isStore(r_inst);
  assign w_lastByte = ((r_idx + 3'd1) == w_curCount);
  assign w_byteSel  = {r_idx[1:0], 3'b000};

`ifdef MISALIGN_CHECK_EN
  assign w_misaligned = ((w_inCount == 3'd2) && mem_address_in[0]) ||
                        ((w_inCount == 3'd4) && (mem_address_in[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  // Little-endian accumulator extended according to the latched load flavour.
  always_comb begin
    case (r_inst)
      `INST_LB:  w_loadData = {{(XLEN-8){r_acc[7]}}, r_acc[7:0]};
      `INST_LH:  w_loadData = {{(XLEN-16){r_acc[15]}}, r_acc[15:0]};
      `INST_LBU: w_loadData = {{(XLEN-8){1'b0}}, r_acc[7:0]};
      `INST_LHU: w_loadData = {{(XLEN-16){1'b0}}, r_acc[15:0]};
      default:   w_loadData = XLEN'(r_acc);
    endcase
  end

  // Outputs are combinational from state so the stall and the pass-through path act in the arrival cycle.
  always_comb begin
    w_next         = r_state;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    stall_req      = 1'b0;
    rd_address_out = '0;
    rd_data_out    = '0;
    mem_rd_done    = 1'b0;
    misalign_err   = 1'b0;
    if (!rst_in) begin
      case (r_state)
        IDLE: begin
          if (w_inMem && w_misaligned) begin
            misalign_err = 1'b1;
          end else if (w_inMem) begin
            stall_req = 1'b1;
            if (rdy_in) w_next = REQ;
          end else begin
            rd_address_out = rd_address_in;
            rd_data_out    = rd_data_in;
            mem_rd_done    = (rd_address_in != '0);
          end
        end
        REQ: begin
          stall_req = 1'b1;
          mem_req   = rdy_in;
          mem_addr  = r_addr + ADDR_W'(r_idx);
          if (w_curStore) begin
            mem_we    = 1'b1;
            mem_wdata = r_data[w_byteSel +: 8];
          end
          if (rdy_in && mem_grant) begin
            if (!w_curStore)     w_next = WAIT;
            else if (w_lastByte) w_next = DONE;
            else                 w_next = REQ;
          end
        end
        WAIT: begin
          stall_req = 1'b1;
          if (rdy_in && mem_rvalid) w_next = w_lastByte ? DONE : REQ;
        end
        DONE: begin
          stall_req = !rdy_in;
          if (!w_curStore) begin
            rd_address_out = r_rd;
            rd_data_out    = w_loadData;
            mem_rd_done    = (r_rd != '0);
          end
          if (rdy_in) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // A stalled global ready freezes everything, including the byte index and accumulator.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_inst  <= '0;
      r_addr  <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
    end else if (rdy_in) begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_next == REQ) begin
            r_inst <= inst_in;
            r_addr <= mem_address_in;
            r_rd   <= rd_address_in;
            r_data <= rd_data_in;
            r_idx  <= '0;
            r_acc  <= '0;
          end
        end
        REQ: begin
          if (mem_grant && w_curStore) r_idx <= r_idx + 3'd1;
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_acc[w_byteSel +: 8] <= mem_rdata;
            r_idx                 <= r_idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a byte-wide memory responder plus a word-level load/store reference model.
// Build with MISALIGN_CHECK_EN defined to exercise the misalignment rejection path.
`ifndef RegAddressBus
`define RegAddressBus 4:0
`endif
`ifndef InstShort
`define InstShort 5:0
`endif
`ifndef MEM_STAGE_INST_CODES
`define MEM_STAGE_INST_CODES
`define INST_NOP  6'd0
`define INST_ADDI 6'd1
`define INST_LB   6'd10
`define INST_LH   6'd11
`define INST_LW   6'd12
`define INST_LBU  6'd13
`define INST_LHU  6'd14
`define INST_SB   6'd15
`define INST_SH   6'd16
`define INST_SW   6'd17
`endif

module tb_mem_stage;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  rdy_in;
  logic [`RegAddressBus] rd_address_in;
  logic [31:0]           rd_data_in;
  logic [`InstShort]     inst_in;
  logic [31:0]           mem_address_in;
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_grant;
  logic                  mem_rvalid;
  logic [7:0]            mem_rdata;
  logic                  stall_req;
  logic [`RegAddressBus] rd_address_out;
  logic [31:0]           rd_data_out;
  logic                  mem_rd_done;
  logic                  misalign_err;

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rd_address_in(rd_address_in), .rd_data_in(rd_data_in), .inst_in(inst_in),
    .mem_address_in(mem_address_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_grant(mem_grant), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .rd_address_out(rd_address_out), .rd_data_out(rd_data_out),
    .mem_rd_done(mem_rd_done), .misalign_err(misalign_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t        reqLog[$];
  logic [31:0] heldAddrs[$];
  logic [7:0]  memModel [logic [31:0]];

  int total = 0;
  int bad = 0;

  int   extraCycles = 0;
  int   grantsSeen = 0;
  int   holdIndex = -1;
  int   holdCycles = 0;
  int   holdLeft = 0;
  bit   holdArmed = 1'b0;
  bit   randomDelays = 1'b0;
  bit   rvPending = 1'b0;
  int   rvWait = 0;
  logic [7:0] rvData = 8'h00;

  function automatic logic [7:0] memRead(input logic [31:0] a);
    if (memModel.exists(a)) return memModel[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic int bytesOf(input logic [5:0] inst);
    if (inst == `INST_LB || inst == `INST_LBU || inst == `INST_SB) return 1;
    if (inst == `INST_LH || inst == `INST_LHU || inst == `INST_SH) return 2;
    if (inst == `INST_LW || inst == `INST_SW) return 4;
    return 0;
  endfunction

  function automatic bit isLoad(input logic [5:0] inst);
    return (inst == `INST_LB || inst == `INST_LH || inst == `INST_LW ||
            inst == `INST_LBU || inst == `INST_LHU);
  endfunction

  // Reference load: sum bytes as a little-endian number, then apply two's-complement for signed flavours.
  function automatic logic [31:0] loadModel(input logic [5:0] inst, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = bytesOf(inst);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v + ({24'd0, memRead(addr + 32'(i))} << (8 * i));
    if (inst == `INST_LB && v >= 32'd128) v = v - 32'd256;
    if (inst == `INST_LH && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  // Memory controller: grants (optionally after a hold), returns read data at least one cycle after grant.
  initial begin
    mem_grant  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    forever begin
      @(posedge clk_in);
      #2;
      mem_grant  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
      if (rvPending) begin
        if (rvWait > 0) begin
          rvWait--;
          extraCycles++;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata  = rvData;
          rvPending  = 1'b0;
        end
      end else if (mem_req === 1'b1) begin
        if (!holdArmed) begin
          holdArmed = 1'b1;
          if (grantsSeen == holdIndex) holdLeft = holdCycles;
          else if (randomDelays)       holdLeft = int'($urandom_range(0, 2));
          else                         holdLeft = 0;
        end
        if (holdLeft > 0) begin
          holdLeft--;
          extraCycles++;
          heldAddrs.push_back(mem_addr);
        end else begin
          mem_grant = 1'b1;
          holdArmed = 1'b0;
          grantsSeen++;
          reqLog.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
          if (mem_we) begin
            memModel[mem_addr] = mem_wdata;
          end else begin
            rvPending = 1'b1;
            rvData    = memRead(mem_addr);
            rvWait    = randomDelays ? int'($urandom_range(0, 2)) : 0;
          end
        end
      end
    end
  end

  task automatic clearLogs();
    reqLog.delete();
    heldAddrs.delete();
    extraCycles = 0;
    grantsSeen  = 0;
    holdArmed   = 1'b0;
  endtask

  task automatic setNop();
    inst_in        = `INST_NOP;
    rd_address_in  = '0;
    rd_data_in     = 32'd0;
    mem_address_in = 32'd0;
  endtask

  // Presents one instruction, holds it while stalled, and captures outputs in the first unstalled cycle.
  task automatic runOp(input logic [5:0] inst, input logic [31:0] addr, input logic [4:0] rd,
                       input logic [31:0] data, output int stalls, output logic [4:0] rdo,
                       output logic [31:0] rdd, output logic dn);
    int guard;
    clearLogs();
    @(posedge clk_in);
    #1;
    inst_in        = inst;
    mem_address_in = addr;
    rd_address_in  = rd;
    rd_data_in     = data;
    stalls = 0;
    guard  = 0;
    @(negedge clk_in);
    while (stall_req === 1'b1 && guard < 200) begin
      stalls++;
      guard++;
      @(negedge clk_in);
    end
    if (guard >= 200) stalls = 9999;
    rdo = rd_address_out;
    rdd = rd_data_out;
    dn  = mem_rd_done;
    @(posedge clk_in);
    #1;
    setNop();
  endtask

  task automatic test_reset();
    rst_in         = 1'b1;
    rdy_in         = 1'b1;
    inst_in        = `INST_ADDI;
    rd_address_in  = 5'd3;
    rd_data_in     = 32'd7;
    mem_address_in = 32'd0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 8'd0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    total++; if (rd_address_out !== 5'd0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_address_out); end
    total++; if (rd_data_out !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data_out); end
    total++; if (mem_rd_done !== 1'b0) begin bad++; $display("FAIL reset_rd_done: got %b want 0", mem_rd_done); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    setNop();
  endtask

  task automatic test_passthrough();
    logic [4:0]  rd;
    logic [31:0] data;
    for (int k = 0; k < 5; k++) begin
      rd   = (k == 0) ? 5'd3 : ((k == 1) ? 5'd0 : 5'($urandom));
      data = (k == 0) ? 32'd7 : $urandom;
      @(posedge clk_in);
      #1;
      inst_in       = `INST_ADDI;
      rd_address_in = rd;
      rd_data_in    = data;
      @(negedge clk_in);
      total++; if (rd_address_out !== rd) begin bad++; $display("FAIL pass_rd_addr: got %0d want %0d", rd_address_out, rd); end
      total++; if (rd_data_out !== data) begin bad++; $display("FAIL pass_rd_data: got %h want %h", rd_data_out, data); end
      total++; if (mem_rd_done !== (rd != 5'd0)) begin bad++; $display("FAIL pass_rd_done: got %b want %b", mem_rd_done, rd != 5'd0); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL pass_stall: got %b want 0", stall_req); end
    end
    @(posedge clk_in);
    #1;
    setNop();
  endtask

  task automatic test_lb();
    int stalls; logic [4:0] rdo; logic [31:0] rdd; logic dn;
    memModel[32'h100] = 8'h80;
    runOp(`INST_LB, 32'h100, 5'd5, 32'h0, stalls, rdo, rdd, dn);
    total++; if (stalls !== 3) begin bad++; $display("FAIL lb_stall_cycles: got %0d want 3", stalls); end
    total++; if (rdo !== 5'd5) begin bad++; $display("FAIL lb_rd_addr: got %0d want 5", rdo); end
    total++; if (rdd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rd_data: got %h want ffffff80", rdd); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL lb_rd_done: got %b want 1", dn); end
    total++; if (reqLog.size() != 1 || reqLog[0].addr !== 32'h100 || reqLog[0].we !== 1'b0) begin
      bad++; $display("FAIL lb_request: got %0d requests want one read of 00000100", reqLog.size());
    end
  endtask

  task automatic test_lhu();
    int stalls; logic [4:0] rdo; logic [31:0] rdd; logic dn;
    memModel[32'h102] = 8'h34;
    memModel[32'h103] = 8'h12;
    runOp(`INST_LHU, 32'h102, 5'd9, 32'h0, stalls, rdo, rdd, dn);
    total++; if (rdd !== 32'h00001234) begin bad++; $display("FAIL lhu_rd_data: got %h want 00001234", rdd); end
    total++; if (stalls !== 5) begin bad++; $display("FAIL lhu_stall_cycles: got %0d want 5", stalls); end
    total++; if (reqLog.size() != 2 || reqLog[0].addr !== 32'h102 || reqLog[1].addr !== 32'h103) begin
      bad++; $display("FAIL lhu_requests: got %0d requests want reads of 00000102,00000103", reqLog.size());
    end
  endtask

  task automatic test_lw_grant_hold();
    int stalls; logic [4:0] rdo; logic [31:0] rdd; logic dn;
    memModel[32'h200] = 8'h78;
    memModel[32'h201] = 8'h56;
    memModel[32'h202] = 8'h34;
    memModel[32'h203] = 8'h12;
    holdIndex  = 2;
    holdCycles = 2;
    runOp(`INST_LW, 32'h200, 5'd7, 32'h0, stalls, rdo, rdd, dn);
    holdIndex  = -1;
    total++; if (rdd !== 32'h12345678) begin bad++; $display("FAIL lw_rd_data: got %h want 12345678", rdd); end
    total++; if (stalls !== 11) begin bad++; $display("FAIL lw_stall_cycles: got %0d want 11", stalls); end
    total++; if (heldAddrs.size() != 2) begin bad++; $display("FAIL lw_held_count: got %0d want 2", heldAddrs.size()); end
    foreach (heldAddrs[i]) begin
      total++; if (heldAddrs[i] !== 32'h202) begin bad++; $display("FAIL lw_held_addr: got %h want 00000202", heldAddrs[i]); end
    end
  endtask

  task automatic test_sw();
    int stalls; logic [4:0] rdo; logic [31:0] rdd; logic dn;
    logic [7:0] expBytes [4];
    expBytes[0] = 8'hEF; expBytes[1] = 8'hBE; expBytes[2] = 8'hAD; expBytes[3] = 8'hDE;
    runOp(`INST_SW, 32'h300, 5'd4, 32'hDEADBEEF, stalls, rdo, rdd, dn);
    total++; if (stalls !== 5) begin bad++; $display("FAIL sw_stall_cycles: got %0d want 5", stalls); end
    total++; if (rdo !== 5'd0 || rdd !== 32'd0 || dn !== 1'b0) begin
      bad++; $display("FAIL sw_done_outputs: got rd=%0d data=%h done=%b want 0/0/0", rdo, rdd, dn);
    end
    total++; if (reqLog.size() != 4) begin bad++; $display("FAIL sw_request_count: got %0d want 4", reqLog.size()); end
    for (int i = 0; i < reqLog.size() && i < 4; i++) begin
      total++;
      if (reqLog[i].we !== 1'b1 || reqLog[i].addr !== 32'h300 + 32'(i) || reqLog[i].data !== expBytes[i]) begin
        bad++; $display("FAIL sw_byte%0d: got we=%b addr=%h data=%h want 1 %h %h", i, reqLog[i].we,
                        reqLog[i].addr, reqLog[i].data, 32'h300 + 32'(i), expBytes[i]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    clearLogs();
    @(posedge clk_in);
    #1;
    inst_in        = `INST_LW;
    mem_address_in = 32'h400;
    rd_address_in  = 5'd6;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    setNop();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", stall_req); end
    end
    total++; if (reqLog.size() != 1) begin bad++; $display("FAIL rstmid_requests: got %0d want 1", reqLog.size()); end
  endtask

  task automatic test_ready_freeze();
    clearLogs();
    @(posedge clk_in);
    #1;
    inst_in        = `INST_SB;
    mem_address_in = 32'h500;
    rd_data_in     = 32'h123456A5;
    @(posedge clk_in);
    #1;
    rdy_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_in);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL freeze_mem_req: got %b want 0", mem_req); end
      total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL freeze_stall: got %b want 1", stall_req); end
      @(posedge clk_in);
    end
    #1;
    rdy_in = 1'b1;
    @(negedge clk_in);
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 8'hA5) begin
      bad++; $display("FAIL freeze_resume: got req=%b we=%b addr=%h data=%h want 1 1 00000500 a5",
                      mem_req, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk_in);
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL freeze_done_stall: got %b want 0", stall_req); end
    @(posedge clk_in);
    #1;
    setNop();
    total++; if (reqLog.size() != 1) begin bad++; $display("FAIL freeze_requests: got %0d want 1", reqLog.size()); end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_CHECK_EN
    clearLogs();
    @(posedge clk_in);
    #1;
    inst_in        = `INST_LW;
    mem_address_in = 32'h201;
    rd_address_in  = 5'd4;
    @(negedge clk_in);
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL misalign_pulse: got %b want 1", misalign_err); end
    total++; if (mem_req !== 1'b0 || stall_req !== 1'b0 || rd_address_out !== 5'd0) begin
      bad++; $display("FAIL misalign_quiet: got req=%b stall=%b rd=%0d want 0 0 0", mem_req, stall_req, rd_address_out);
    end
    @(posedge clk_in);
    #1;
    setNop();
    @(negedge clk_in);
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL misalign_clear: got %b want 0", misalign_err); end
    repeat (2) @(posedge clk_in);
    total++; if (reqLog.size() != 0) begin bad++; $display("FAIL misalign_requests: got %0d want 0", reqLog.size()); end
`else
    int stalls; logic [4:0] rdo; logic [31:0] rdd; logic dn;
    memModel[32'h201] = 8'h11;
    memModel[32'h202] = 8'h22;
    memModel[32'h203] = 8'h33;
    memModel[32'h204] = 8'h44;
    runOp(`INST_LW, 32'h201, 5'd4, 32'h0, stalls, rdo, rdd, dn);
    total++; if (rdd !== 32'h44332211) begin bad++; $display("FAIL unaligned_lw_data: got %h want 44332211", rdd); end
    total++; if (reqLog.size() != 4 || reqLog[0].addr !== 32'h201 || reqLog[3].addr !== 32'h204) begin
      bad++; $display("FAIL unaligned_lw_requests: got %0d requests want 00000201..00000204", reqLog.size());
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] addr, data, expData;
    logic [4:0]  rd, expRd;
    logic        expDone;
    int          n, expStalls, stalls;
    logic [4:0]  rdo; logic [31:0] rdd; logic dn;
    ops[0] = `INST_LB;  ops[1] = `INST_LH;  ops[2] = `INST_LW;
    ops[3] = `INST_LBU; ops[4] = `INST_LHU; ops[5] = `INST_SB;
    ops[6] = `INST_SH;  ops[7] = `INST_SW;  ops[8] = `INST_ADDI;
    randomDelays = 1'b1;
    for (int k = 0; k < 40; k++) begin
      op   = ops[$urandom_range(0, 8)];
      n    = bytesOf(op);
      addr = (k % 8 == 7) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : {20'h0, 12'($urandom)};
`ifdef MISALIGN_CHECK_EN
      if (n == 2) addr[0] = 1'b0;
      if (n == 4) addr[1:0] = 2'b00;
`endif
      data = $urandom;
      rd   = 5'($urandom);
      if (isLoad(op)) begin
        expData = loadModel(op, addr); expRd = rd; expDone = (rd != 5'd0);
      end else if (n > 0) begin
        expData = 32'd0; expRd = 5'd0; expDone = 1'b0;
      end else begin
        expData = data; expRd = rd; expDone = (rd != 5'd0);
      end
      runOp(op, addr, rd, data, stalls, rdo, rdd, dn);
      expStalls = (n == 0) ? 0 : 1 + (isLoad(op) ? 2 * n : n) + extraCycles;
      total++; if (stalls !== expStalls) begin bad++; $display("FAIL rand%0d_stalls op=%0d: got %0d want %0d", k, op, stalls, expStalls); end
      total++; if (rdd !== expData) begin bad++; $display("FAIL rand%0d_data op=%0d: got %h want %h", k, op, rdd, expData); end
      total++; if (rdo !== expRd || dn !== expDone) begin
        bad++; $display("FAIL rand%0d_rd op=%0d: got rd=%0d done=%b want %0d %b", k, op, rdo, dn, expRd, expDone);
      end
      total++; if (reqLog.size() != n) begin bad++; $display("FAIL rand%0d_reqcount: got %0d want %0d", k, reqLog.size(), n); end
      for (int i = 0; i < reqLog.size() && i < n; i++) begin
        total++;
        if (reqLog[i].addr !== addr + 32'(i) || reqLog[i].we !== !isLoad(op) ||
            (!isLoad(op) && reqLog[i].data !== 8'((data >> (8 * i)) & 32'hFF))) begin
          bad++; $display("FAIL rand%0d_byte%0d: got we=%b addr=%h data=%h want addr %h", k, i,
                          reqLog[i].we, reqLog[i].addr, reqLog[i].data, addr + 32'(i));
        end
      end
    end
    randomDelays = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    setNop();
    test_reset();
    test_passthrough();
    test_lb();
    test_lhu();
    test_lw_grant_hold();
    test_sw();
    test_reset_mid_access();
    test_ready_freeze();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
